sudoku_cursor_ctrl: RTL

Parametrised cursor and write controller for an N×N Sudoku board held in a synchronous-read row RAM. It replaces the fixed 4×4 interface controller. It adds edge-detected buttons, a sequenced read-modify-write, a clear command, digit range checking and in-row duplicate rejection. It sits between the button/switch debouncers and the board RAM, and feeds the row display decoder.

---
 rtl/sudoku_cursor_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sudoku_cursor_ctrl.sv
// Cursor and read-modify-write controller for an N x N Sudoku board in a synchronous-read row RAM.
// Buttons are edge detected; write/clear run LOAD -> EVAL -> WRITE with range and in-row duplicate checks.
module sudoku_cursor_ctrl #(
    parameter int N  = 4,
    parameter int DW = 4,
    localparam int AW = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int WW = 2 * N + N * DW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [DW-1:0]   userNum,
    input  logic            upButton,
    input  logic            downButton,
    input  logic            leftButton,
    input  logic            rightButton,
    input  logic            writeBit,
    input  logic            clearBit,
    output logic [N*DW-1:0] currentRow,
    output logic [N-1:0]    currentCol,
    output logic            noWrite,
    output logic            badDigit,
    output logic            dupDigit,
    output logic            busy,
    output logic [AW-1:0]   RamAddr,
    input  logic [WW-1:0]   RamDat,
    output logic            RamWriteBit,
    output logic [WW-1:0]   RamWriteBuf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] EVAL  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [AW-1:0] LASTROW = AW'(N - 1);
    localparam logic [DW-1:0] MAXNUM  = DW'(N);

    logic [1:0] state;
    logic       cmdClear;
    logic       upPrev, downPrev, leftPrev, rightPrev, writePrev, clearPrev;
    logic       upEdge, downEdge, leftEdge, rightEdge, writeEdge, clearEdge;

    logic [N-1:0]  protBits;
    logic [N-1:0]  blankBits;
    logic          isProt;
    logic          isBad;
    logic          isDup;
    logic [WW-1:0] newWord;

    assign upEdge    = upButton    & ~upPrev;
    assign downEdge  = downButton  & ~downPrev;
    assign leftEdge  = leftButton  & ~leftPrev;
    assign rightEdge = rightButton & ~rightPrev;
    assign writeEdge = writeBit    & ~writePrev;
    assign clearEdge = clearBit    & ~clearPrev;

    assign currentRow  = RamDat[N*DW-1:0];
    assign busy        = (state != IDLE);
    assign RamWriteBit = (state == WRITE);

    assign protBits  = RamDat[WW-1 -: N];
    assign blankBits = RamDat[WW-N-1 -: N];
    assign isProt    = |(protBits & currentCol);
    assign isBad     = (userNum == '0) || (userNum > MAXNUM);

    // The selected column is excluded so rewriting a cell with its own digit is legal.
    always_comb begin
        isDup   = 1'b0;
        newWord = RamDat;
        for (int unsigned c = 0; c < N; c++) begin
            if (!currentCol[c] && !blankBits[c] && (RamDat[c*DW +: DW] == userNum))
                isDup = 1'b1;
            if (currentCol[c]) begin
                newWord[c*DW +: DW] = cmdClear ? '0 : userNum;
                newWord[N*DW + c]   = cmdClear;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            upPrev      <= 1'b1;
            downPrev    <= 1'b1;
            leftPrev    <= 1'b1;
            rightPrev   <= 1'b1;
            writePrev   <= 1'b1;
            clearPrev   <= 1'b1;
            state       <= IDLE;
            cmdClear    <= 1'b0;
            RamAddr     <= '0;
            currentCol  <= N'(1);
            RamWriteBuf <= '0;
            noWrite     <= 1'b0;
            badDigit    <= 1'b0;
            dupDigit    <= 1'b0;
        end else begin
            upPrev    <= upButton;
            downPrev  <= downButton;
            leftPrev  <= leftButton;
            rightPrev <= rightButton;
            writePrev <= writeBit;
            clearPrev <= clearBit;
            case (state)
                IDLE: begin
                    if (clearEdge || writeEdge) begin
                        cmdClear <= clearEdge;
                        noWrite  <= 1'b0;
                        badDigit <= 1'b0;
                        dupDigit <= 1'b0;
                        state    <= LOAD;
                    end else if (leftEdge) begin
                        currentCol <= {currentCol[N-2:0], currentCol[N-1]};
                    end else if (rightEdge) begin
                        currentCol <= {currentCol[0], currentCol[N-1:1]};
                    end else if (upEdge) begin
                        RamAddr <= (RamAddr == '0) ? LASTROW : RamAddr - 1'b1;
                    end else if (downEdge) begin
                        RamAddr <= (RamAddr == LASTROW) ? '0 : RamAddr + 1'b1;
                    end
                end
                LOAD: state <= EVAL;
                EVAL: begin
                    if (isProt) begin
                        noWrite <= 1'b1;
                        state   <= IDLE;
                    end else if (cmdClear) begin
                        RamWriteBuf <= newWord;
                        state       <= WRITE;
                    end else if (isBad) begin
                        badDigit <= 1'b1;
                        state    <= IDLE;
                    end else if (isDup) begin
                        dupDigit <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        RamWriteBuf <= newWord;
                        state       <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
